// File: rtl/mem_responder.sv
// Memory-side responder: one request from the core becomes one
// valid/ready SRAM bus transaction with lane steering and load extension.
module mem_responder #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en_mem,
  input  logic [1:0]  W_R_mem,
  input  logic [1:0]  wordsize_mem,
  input  logic        sign_mem,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        done_mem,
  output logic        busy_mem,
  output logic        aligned_mem,
  output logic        bus_err,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LIM =
    (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;
  localparam logic TMO_ON = (TIMEOUT > 0);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2,
    ERR  = 2'd3
  } state_t;

  state_t state, state_d;

  logic [CW-1:0] cnt;
  logic [1:0]    cap_size;
  logic [1:0]    cap_off;
  logic          cap_sign;
  logic          cap_rd;
  logic          cap_raw;

  logic          is_fetch;
  logic          is_store;
  logic          legal;
  logic          accept;
  logic          reject;
  logic          tmo;
  logic          finish;
  logic [3:0]    strb_n;
  logic [31:0]   wdat_n;
  logic [31:0]   byte_sh;
  logic [31:0]   half_sh;
  logic [31:0]   load_v;

  assign is_fetch = (W_R_mem == 2'b11);
  assign is_store = (W_R_mem == 2'b01);

  // Alignment / size legality of the request presented in IDLE
  always_comb begin
    legal = 1'b0;
    if (is_fetch) begin
      legal = (addr[1:0] == 2'b00);
    end else begin
      unique case (wordsize_mem)
        2'b00:   legal = 1'b1;
        2'b01:   legal = ~addr[0];
        2'b10:   legal = (addr[1:0] == 2'b00);
        default: legal = 1'b0;
      endcase
    end
  end

  assign accept = (state == IDLE) && en_mem && legal;
  assign reject = (state == IDLE) && en_mem && !legal;

  assign tmo = TMO_ON && (state == REQ) &&
               !mem_ready && (cnt == LIM);
  assign finish = (state == REQ) && mem_ready;

  // Byte-lane steering for stores; reads never enable a lane
  always_comb begin
    strb_n = 4'b0000;
    wdat_n = wdata;
    if (is_store) begin
      unique case (wordsize_mem)
        2'b00: begin
          strb_n = 4'b0001 << addr[1:0];
          wdat_n = {4{wdata[7:0]}};
        end
        2'b01: begin
          strb_n = 4'b0011 << addr[1:0];
          wdat_n = {2{wdata[15:0]}};
        end
        default: begin
          strb_n = 4'b1111;
          wdat_n = wdata;
        end
      endcase
    end
  end

  // Lane extraction and sign/zero extension of returned read data
  always_comb begin
    byte_sh = mem_rdata >> {cap_off, 3'b000};
    half_sh = mem_rdata >> {cap_off[1], 4'b0000};
    load_v  = mem_rdata;
    if (!cap_raw) begin
      unique case (cap_size)
        2'b00:
          load_v = {{24{cap_sign & byte_sh[7]}},
                    byte_sh[7:0]};
        2'b01:
          load_v = {{16{cap_sign & half_sh[15]}},
                    half_sh[15:0]};
        default: load_v = mem_rdata;
      endcase
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_d;
  end

  // Next-state logic and state-decoded outputs
  always_comb begin
    state_d   = state;
    mem_valid = 1'b0;
    busy_mem  = 1'b0;
    done_mem  = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept)      state_d = REQ;
        else if (reject) state_d = ERR;
      end
      REQ: begin
        mem_valid = 1'b1;
        busy_mem  = 1'b1;
        if (finish || tmo) state_d = DONE;
      end
      DONE: begin
        done_mem = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = ERR;
    endcase
  end

  // Request capture, bus registers, timeout counter and status flags
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata       <= '0;
      aligned_mem <= 1'b1;
      bus_err     <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      mem_wstrb   <= '0;
      cnt         <= '0;
      cap_size    <= '0;
      cap_off     <= '0;
      cap_sign    <= 1'b0;
      cap_rd      <= 1'b0;
      cap_raw     <= 1'b0;
    end else begin
      if (accept) begin
        mem_addr  <= {addr[31:2], 2'b00};
        mem_wdata <= wdat_n;
        mem_wstrb <= strb_n;
        cap_size  <= wordsize_mem;
        cap_off   <= addr[1:0];
        cap_sign  <= sign_mem;
        cap_rd    <= !is_store;
        cap_raw   <= is_fetch;
      end
      if (reject) aligned_mem <= 1'b0;
      if (state == REQ && !finish && !tmo)
        cnt <= cnt + 1'b1;
      else
        cnt <= '0;
      if (finish && cap_rd) rdata <= load_v;
      if (tmo) begin
        rdata   <= '0;
        bus_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder with a short bus timeout.
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        en_mem;
  logic [1:0]  W_R_mem;
  logic [1:0]  wordsize_mem;
  logic        sign_mem;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        done_mem;
  logic        busy_mem;
  logic        aligned_mem;
  logic        bus_err;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;

  int total = 0;
  int bad = 0;
  logic prev_done = 1'b0;

  always #5 clk = ~clk;

  mem_responder #(.TIMEOUT(4)) dut (
    .clk(clk), .reset(reset), .en_mem(en_mem),
    .W_R_mem(W_R_mem), .wordsize_mem(wordsize_mem),
    .sign_mem(sign_mem), .addr(addr), .wdata(wdata),
    .rdata(rdata), .done_mem(done_mem), .busy_mem(busy_mem),
    .aligned_mem(aligned_mem), .bus_err(bus_err),
    .mem_valid(mem_valid), .mem_ready(mem_ready),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // done_mem must never stay high two cycles in a row
  always @(negedge clk) begin
    if (reset === 1'b0) begin
      total++;
      assert (!(prev_done && done_mem)) else begin
        bad++;
        $error("FAIL done_twice: observed=11 expected=not 11");
      end
    end
    prev_done = done_mem;
  end

  initial begin
    reset = 1'b1; en_mem = 1'b0; W_R_mem = 2'b00;
    wordsize_mem = 2'b10; sign_mem = 1'b0;
    addr = '0; wdata = '0; mem_ready = 1'b0; mem_rdata = '0;
    step(); step();
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_done", {31'b0, done_mem}, 32'h0);
    chk("rst_busy", {31'b0, busy_mem}, 32'h0);
    chk("rst_aligned", {31'b0, aligned_mem}, 32'h1);
    chk("rst_buserr", {31'b0, bus_err}, 32'h0);
    chk("rst_valid", {31'b0, mem_valid}, 32'h0);
    chk("rst_maddr", mem_addr, 32'h0);
    chk("rst_wstrb", {28'b0, mem_wstrb}, 32'h0);
    reset = 1'b0;
    step();

    // Instruction fetch, one wait cycle
    en_mem = 1'b1; W_R_mem = 2'b11; addr = 32'h100;
    step();
    en_mem = 1'b0;
    chk("f_valid", {31'b0, mem_valid}, 32'h1);
    chk("f_busy", {31'b0, busy_mem}, 32'h1);
    chk("f_maddr", mem_addr, 32'h100);
    chk("f_wstrb", {28'b0, mem_wstrb}, 32'h0);
    chk("f_nodone", {31'b0, done_mem}, 32'h0);
    mem_ready = 1'b1; mem_rdata = 32'h00500093;
    step();
    mem_ready = 1'b0;
    chk("f_done", {31'b0, done_mem}, 32'h1);
    chk("f_validlo", {31'b0, mem_valid}, 32'h0);
    chk("f_rdata", rdata, 32'h00500093);
    step();
    chk("f_done_end", {31'b0, done_mem}, 32'h0);

    // Signed byte load, zero-wait bus
    en_mem = 1'b1; W_R_mem = 2'b00; wordsize_mem = 2'b00;
    sign_mem = 1'b1; addr = 32'h203;
    mem_ready = 1'b1; mem_rdata = 32'h80FF0000;
    step();
    en_mem = 1'b0;
    chk("lb_maddr", mem_addr, 32'h200);
    step();
    chk("lb_done", {31'b0, done_mem}, 32'h1);
    chk("lb_rdata", rdata, 32'hFFFFFF80);
    mem_ready = 1'b0;
    step();

    // Unsigned byte load, same lane
    en_mem = 1'b1; sign_mem = 1'b0; mem_ready = 1'b1;
    step();
    en_mem = 1'b0;
    step();
    chk("lbu_done", {31'b0, done_mem}, 32'h1);
    chk("lbu_rdata", rdata, 32'h00000080);
    mem_ready = 1'b0;
    step();

    // Half store, 3 wait cycles; ready lands on the timeout edge
    en_mem = 1'b1; W_R_mem = 2'b01; wordsize_mem = 2'b01;
    addr = 32'h12; wdata = 32'hABCD1234;
    step();
    en_mem = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("sh_valid", {31'b0, mem_valid}, 32'h1);
      chk("sh_wstrb", {28'b0, mem_wstrb}, 32'hC);
      chk("sh_wdata", mem_wdata, 32'h12341234);
      chk("sh_maddr", mem_addr, 32'h10);
      if (i < 3) step();
    end
    mem_ready = 1'b1;
    step();
    mem_ready = 1'b0;
    chk("sh_done", {31'b0, done_mem}, 32'h1);
    chk("sh_noerr", {31'b0, bus_err}, 32'h0);
    chk("sh_rdata", rdata, 32'h00000080);
    en_mem = 1'b1; W_R_mem = 2'b11; addr = 32'h400;
    step();
    en_mem = 1'b0;
    chk("sh_done_end", {31'b0, done_mem}, 32'h0);
    chk("sh_done_ign", {31'b0, mem_valid}, 32'h0);

    // Timeout: word load with mem_ready held low
    en_mem = 1'b1; W_R_mem = 2'b00; wordsize_mem = 2'b10;
    addr = 32'h40; mem_rdata = 32'h12345678;
    step();
    en_mem = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("to_valid", {31'b0, mem_valid}, 32'h1);
      step();
    end
    chk("to_valid4", {31'b0, mem_valid}, 32'h1);
    step();
    chk("to_validlo", {31'b0, mem_valid}, 32'h0);
    chk("to_done", {31'b0, done_mem}, 32'h1);
    chk("to_buserr", {31'b0, bus_err}, 32'h1);
    chk("to_rdata", rdata, 32'h0);
    step();
    chk("to_sticky", {31'b0, bus_err}, 32'h1);

    // Misaligned word load goes to the error state
    en_mem = 1'b1; addr = 32'h6;
    step();
    en_mem = 1'b0;
    chk("mis_aligned", {31'b0, aligned_mem}, 32'h0);
    chk("mis_valid", {31'b0, mem_valid}, 32'h0);
    en_mem = 1'b1; W_R_mem = 2'b11; addr = 32'h100;
    step();
    en_mem = 1'b0;
    step();
    chk("err_valid", {31'b0, mem_valid}, 32'h0);
    chk("err_done", {31'b0, done_mem}, 32'h0);
    chk("err_busy", {31'b0, busy_mem}, 32'h0);
    chk("err_aligned", {31'b0, aligned_mem}, 32'h0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rec_aligned", {31'b0, aligned_mem}, 32'h1);
    chk("rec_buserr", {31'b0, bus_err}, 32'h0);

    // Reset during REQ, with a second strobe ignored in REQ
    en_mem = 1'b1; W_R_mem = 2'b11; addr = 32'h200;
    step();
    en_mem = 1'b0;
    step();
    en_mem = 1'b1; addr = 32'h300;
    step();
    en_mem = 1'b0;
    chk("rr_maddr", mem_addr, 32'h200);
    chk("rr_valid", {31'b0, mem_valid}, 32'h1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rr_validlo", {31'b0, mem_valid}, 32'h0);
    chk("rr_nodone", {31'b0, done_mem}, 32'h0);
    step();
    chk("rr_noxtra", {31'b0, mem_valid}, 32'h0);
    chk("rr_nodone2", {31'b0, done_mem}, 32'h0);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
